// File: rtl/control.sv
// control: main instruction decoder for the MIPS-style CPU.
//
// Decodes a 32-bit instruction word into a packed 32-bit control word for the
// datapath. Supports LW, SW and R-type ADD/SUB/AND/OR/MUL. Anything else
// decodes to a NOP with the illegal flag set. Decode is combinational; the
// control word is registered, giving exactly one clock of latency.
//
// Ports:
//   clk         - system clock, all state updates on the rising edge
//   rst         - synchronous active-high reset, forces ctrl to all zeros
//   instruction - instruction word, sampled every rising edge
//   ctrl        - registered packed control word:
//                 [31:27] wb_addr     [26:22] rs_addr    [21:17] rt_addr
//                 [16:14] alu_op      [13] alu_src_imm   [12] reg_write
//                 [11] mem_read       [10] mem_write     [9] mem_to_reg
//                 [8] reg_dst_rd      [7] valid          [6] illegal
//                 [5:0] reserved (0)
module control (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instruction,
   output logic [31:0] ctrl
);

   localparam logic [5:0] OpRtype = 6'b000001;
   localparam logic [5:0] OpLw    = 6'b000010;
   localparam logic [5:0] OpSw    = 6'b000011;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnMul = 6'b110010;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluMul = 3'b100;
   localparam logic [2:0] AluNop = 3'b111;

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;
   logic [5:0] funct;

   assign opcode = instruction[31:26];
   assign rs     = instruction[25:21];
   assign rt     = instruction[20:16];
   assign rd     = instruction[15:11];
   assign funct  = instruction[5:0];

   // Decoded fields, packed into ctrl_d below.
   logic [4:0] wb_addr;
   logic [4:0] rs_addr;
   logic [4:0] rt_addr;
   logic [2:0] alu_op;
   logic       alu_src_imm;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       mem_to_reg;
   logic       reg_dst_rd;
   logic       valid;
   logic       illegal;
   logic [31:0] ctrl_d;

   always_comb begin
      // Default is the illegal NOP; legal encodings override it.
      wb_addr     = 5'd0;
      rs_addr     = 5'd0;
      rt_addr     = 5'd0;
      alu_op      = AluNop;
      alu_src_imm = 1'b0;
      reg_write   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_to_reg  = 1'b0;
      reg_dst_rd  = 1'b0;
      valid       = 1'b0;
      illegal     = 1'b1;

      case (opcode)
         OpLw: begin
            wb_addr     = rt;
            rs_addr     = rs;
            rt_addr     = rt;
            alu_op      = AluAdd;
            alu_src_imm = 1'b1;
            reg_write   = 1'b1;
            mem_read    = 1'b1;
            mem_to_reg  = 1'b1;
            valid       = 1'b1;
            illegal     = 1'b0;
         end
         OpSw: begin
            rs_addr     = rs;
            rt_addr     = rt;
            alu_op      = AluAdd;
            alu_src_imm = 1'b1;
            mem_write   = 1'b1;
            valid       = 1'b1;
            illegal     = 1'b0;
         end
         OpRtype: begin
            case (funct)
               FnAdd, FnSub, FnAnd, FnOr, FnMul: begin
                  wb_addr    = rd;
                  rs_addr    = rs;
                  rt_addr    = rt;
                  reg_write  = 1'b1;
                  reg_dst_rd = 1'b1;
                  valid      = 1'b1;
                  illegal    = 1'b0;
                  case (funct)
                     FnSub:   alu_op = AluSub;
                     FnAnd:   alu_op = AluAnd;
                     FnOr:    alu_op = AluOr;
                     FnMul:   alu_op = AluMul;
                     default: alu_op = AluAdd;
                  endcase
               end
               default: ;
            endcase
         end
         default: ;
      endcase

      ctrl_d = {wb_addr, rs_addr, rt_addr, alu_op, alu_src_imm, reg_write,
                mem_read, mem_write, mem_to_reg, reg_dst_rd, valid, illegal, 6'd0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= 32'h0000_0000;
      end else begin
         ctrl <= ctrl_d;
      end
   end

endmodule

// File: tb/tb_control.sv
// tb_control: directed self-checking bench for the control decoder.
module tb_control;

   logic        clk;
   logic        rst;
   logic [31:0] instruction;
   logic [31:0] ctrl;

   int checks;
   int errors;

   control dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .ctrl        (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] Illegal = 32'h0001_C040;

   // Builds an R-type word with rs=1, rt=2.
   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
      rtype = {6'b000001, 5'd1, 5'd2, rd, shamt, funct};
   endfunction

   // Drives inputs, then advances past the next rising edge.
   task automatic step(input logic r, input logic [31:0] instr);
      rst         = r;
      instruction = instr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 32'hFFFF_FFFF);
      checks++;
      if (ctrl !== 32'h0000_0000) begin
         errors++;
         $display("FAIL reset_cycle1: got %h expected %h", ctrl, 32'h0000_0000);
      end
      step(1'b1, rtype(5'd6, 5'd0, 6'b100000));
      checks++;
      if (ctrl !== 32'h0000_0000) begin
         errors++;
         $display("FAIL reset_cycle2: got %h expected %h", ctrl, 32'h0000_0000);
      end
   endtask

   task automatic test_load_store();
      step(1'b0, 32'b000010_00000_00001_0000001101010000);
      checks++;
      if (ctrl !== 32'h0802_3A80) begin
         errors++;
         $display("FAIL lw: got %h expected %h", ctrl, 32'h0802_3A80);
      end
      step(1'b0, 32'b000011_00001_00010_0000001101010010);
      checks++;
      if (ctrl !== 32'h0044_2480) begin
         errors++;
         $display("FAIL sw: got %h expected %h", ctrl, 32'h0044_2480);
      end
   endtask

   task automatic test_rtype();
      logic [31:0] instrs [6];
      logic [31:0] exps   [6];
      instrs[0] = rtype(5'd3, 5'd0, 6'b110010); exps[0] = 32'h1845_1180;
      instrs[1] = rtype(5'd6, 5'd0, 6'b100000); exps[1] = 32'h3044_1180;
      instrs[2] = rtype(5'd7, 5'd0, 6'b100010); exps[2] = 32'h3844_5180;
      instrs[3] = rtype(5'd8, 5'd0, 6'b100100); exps[3] = 32'h4044_9180;
      instrs[4] = rtype(5'd9, 5'd0, 6'b100101); exps[4] = 32'h4844_D180;
      // shamt must not affect decode
      instrs[5] = rtype(5'd6, 5'd17, 6'b100000); exps[5] = 32'h3044_1180;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, instrs[i]);
         checks++;
         if (ctrl !== exps[i]) begin
            errors++;
            $display("FAIL rtype_%0d: got %h expected %h", i, ctrl, exps[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [31:0] instrs [4];
      instrs[0] = 32'b111111_00001_00010_00011_00000_100000;
      instrs[1] = 32'b000000_00001_00010_00011_00000_100000;
      instrs[2] = rtype(5'd3, 5'd0, 6'b000000);
      instrs[3] = rtype(5'd3, 5'd0, 6'b100001);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, instrs[i]);
         checks++;
         if (ctrl !== Illegal) begin
            errors++;
            $display("FAIL illegal_%0d: got %h expected %h", i, ctrl, Illegal);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Alternating encodings: each edge must show the new decode.
      step(1'b0, 32'b000010_00000_00001_0000001101010000);
      checks++;
      if (ctrl !== 32'h0802_3A80) begin
         errors++;
         $display("FAIL b2b_lw: got %h expected %h", ctrl, 32'h0802_3A80);
      end
      step(1'b0, 32'hFC00_0000);
      checks++;
      if (ctrl !== Illegal) begin
         errors++;
         $display("FAIL b2b_illegal: got %h expected %h", ctrl, Illegal);
      end
      step(1'b0, rtype(5'd7, 5'd0, 6'b100010));
      checks++;
      if (ctrl !== 32'h3844_5180) begin
         errors++;
         $display("FAIL b2b_sub: got %h expected %h", ctrl, 32'h3844_5180);
      end
      step(1'b0, 32'b000011_00001_00010_0000001101010010);
      checks++;
      if (ctrl !== 32'h0044_2480) begin
         errors++;
         $display("FAIL b2b_sw: got %h expected %h", ctrl, 32'h0044_2480);
      end
   endtask

   task automatic test_reset_midstream();
      step(1'b0, rtype(5'd9, 5'd0, 6'b100101));
      checks++;
      if (ctrl !== 32'h4844_D180) begin
         errors++;
         $display("FAIL mid_or: got %h expected %h", ctrl, 32'h4844_D180);
      end
      step(1'b1, rtype(5'd6, 5'd0, 6'b100000));
      checks++;
      if (ctrl !== 32'h0000_0000) begin
         errors++;
         $display("FAIL mid_reset: got %h expected %h", ctrl, 32'h0000_0000);
      end
      step(1'b0, rtype(5'd6, 5'd0, 6'b100000));
      checks++;
      if (ctrl !== 32'h3044_1180) begin
         errors++;
         $display("FAIL mid_resume_add: got %h expected %h", ctrl, 32'h3044_1180);
      end
      // Reset over an illegal word also yields zeros, not the illegal NOP.
      step(1'b1, 32'hFFFF_FFFF);
      checks++;
      if (ctrl !== 32'h0000_0000) begin
         errors++;
         $display("FAIL reset_over_illegal: got %h expected %h", ctrl, 32'h0000_0000);
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      instruction = 32'h0;
      @(negedge clk);
      test_reset();
      test_load_store();
      test_rtype();
      test_illegal();
      test_back_to_back();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control.md
Name: control

Overview:
- Main decoder for the MIPS-style CPU.
- Takes the 32-bit instruction word and produces a registered 32-bit packed control word for the datapath (register file, ALU, data memory).
- Supports LW, SW and R-type ADD/SUB/AND/OR/MUL.
- Any unsupported encoding yields a safe NOP with an illegal flag.

Parameters:
- none (all field positions and encodings are fixed by this spec)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instruction  input  32  instruction word; sampled every rising edge
- ctrl  output  32  registered packed control word (fields below)

Behaviour:
- Instruction fields:
  - opcode = instruction[31:26]; rs = [25:21]; rt = [20:16]; rd = [15:11]; shamt = [10:6]; funct = [5:0].
  - [15:0] is the I-type offset; it is not decoded by this block.
- Supported opcodes:
  - 6'b000001 = R-type.
  - 6'b000010 = LW.
  - 6'b000011 = SW.
  - All other opcodes are illegal.
- Supported R-type funct codes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 110010 MUL. Any other funct is illegal. shamt is ignored.
- ctrl field map:
  - [31:27] wb_addr: rd for R-type, rt for LW, 0 otherwise.
  - [26:22] rs_addr.
  - [21:17] rt_addr.
  - [16:14] alu_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 111 NOP.
  - [13] alu_src_imm.
  - [12] reg_write.
  - [11] mem_read.
  - [10] mem_write.
  - [9] mem_to_reg.
  - [8] reg_dst_rd.
  - [7] valid.
  - [6] illegal.
  - [5:0] reserved, always 0.
- LW: wb=rt, rs/rt from the instruction, alu_op=ADD, alu_src_imm=1, reg_write=1, mem_read=1, mem_to_reg=1, valid=1.
- SW: wb=0, rs/rt from the instruction, alu_op=ADD, alu_src_imm=1, mem_write=1, valid=1.
- R-type (legal funct): wb=rd, rs/rt from the instruction, alu_op per funct, reg_write=1, reg_dst_rd=1, valid=1.
- Illegal (bad opcode, or R-type with bad funct):
  - All address fields 0, all enables 0, valid=0.
  - alu_op=111, illegal=1.
  - ctrl = 32'h0001_C040.
- Timing:
  - Decode is combinational; ctrl is registered.
  - Latency is exactly 1 clock: ctrl after edge N reflects the instruction sampled at edge N.
  - New value every cycle; no handshake, no stall.
- Reset:
  - rst=1 at a rising edge forces ctrl=32'h0000_0000 (valid=0, illegal=0). This is the only state where both flags are 0.
  - Reset has priority over decode.
  - Deasserting rst resumes decode on the next edge.
  - Reset asserted mid-stream discards the pending decode.
- Flag invariants: valid and illegal are never both 1. reg_write and mem_write are never both 1.
- X/Z on instruction need not be handled. Only defined inputs are specified.

Test Plan:
- rst=1 for 2 cycles with any instruction -> ctrl=32'h0000_0000. Release rst, apply LW 32'b000010_00000_00001_0000001101010000 -> next edge ctrl=32'h0802_3A80.
- SW 32'b000011_00001_00010_0000001101010010 -> ctrl=32'h0044_2480 one cycle later.
- R-type rs=1, rt=2:
  - MUL rd=3 (funct 110010) -> 32'h1845_1180.
  - ADD rd=6 (100000) -> 32'h3044_1180.
  - SUB rd=7 (100010) -> 32'h3844_5180.
- AND rd=8 (funct 100100) -> 32'h4044_9180. OR rd=9 (100101) -> 32'h4844_D180. Back-to-back instructions change ctrl on every edge.
- Illegal encodings -> ctrl=32'h0001_C040:
  - opcode 111111.
  - opcode 000000.
  - R-type with funct 000000.
- Assert rst in the same cycle a valid ADD is applied -> ctrl=0 at that edge. Deassert -> ADD decode (32'h3044_1180) appears one edge later.
